// File: rtl/ternary_pkg.sv
// Balanced-ternary types and helpers shared by the adder and the arbiter.
package ternary_pkg;

  // 2-bit trit encoding; 2'b11 is never produced by the datapath.
  typedef logic [1:0] trit_t;
  localparam trit_t T_ZERO    = 2'b00;
  localparam trit_t T_POS_ONE = 2'b01;
  localparam trit_t T_NEG_ONE = 2'b10;
  localparam trit_t T_INVALID = 2'b11;

  localparam int TERNARY_ADD_ARB_MAX_REQ = 8;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Negation swaps +1/-1; zero and invalid pass through.
  function automatic trit_t trit_neg(trit_t t);
    case (t)
      T_POS_ONE: return T_NEG_ONE;
      T_NEG_ONE: return T_POS_ONE;
      default:   return t;
    endcase
  endfunction

  // Invalid trits read as zero so a sum is always produced.
  function automatic logic signed [2:0] trit_val(trit_t t);
    case (t)
      T_POS_ONE: return 3'sd1;
      T_NEG_ONE: return -3'sd1;
      default:   return 3'sd0;
    endcase
  endfunction

  function automatic trit_t trit_enc(logic signed [2:0] v);
    if (v == 3'sd1)       return T_POS_ONE;
    else if (v == -3'sd1) return T_NEG_ONE;
    else                  return T_ZERO;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority scan: first asserted request at or after ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found;
  int   idx;

  // Walk offsets 0..NUM_REQ-1 from ptr; the first hit wins, one-hot out.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && j == idx && req[j]) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ternary_cla.sv
// WIDTH-trit balanced-ternary adder with carry in/out.
module ternary_cla
  import ternary_pkg::*;
#(
  parameter int WIDTH = 27
) (
  input  trit_t [WIDTH-1:0] a,
  input  trit_t [WIDTH-1:0] b,
  input  trit_t             cin,
  output trit_t [WIDTH-1:0] sum,
  output trit_t             cout
);

  logic signed [2:0] c;
  logic signed [2:0] s;

  // Per-trit digit sum in -3..3, folded back to -1..1 with a carry of -1/0/+1.
  always_comb begin
    c   = trit_val(cin);
    s   = 3'sd0;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s = trit_val(a[i]) + trit_val(b[i]) + c;
      if (s > 3'sd1) begin
        s = s - 3'sd3;
        c = 3'sd1;
      end else if (s < -3'sd1) begin
        s = s + 3'sd3;
        c = -3'sd1;
      end else begin
        c = 3'sd0;
      end
      sum[i] = trit_enc(s);
    end
    cout = trit_enc(c);
  end

endmodule

// File: rtl/ternary_add_arbiter.sv
// Shares one balanced-ternary adder among NUM_REQ requesters with round-robin
// arbitration, multi-word carry chaining under a lock, and a registered response.
// Optional: TERNARY_ADD_ARB_INVALID_CHK_EN registers an invalid-trit flag.
module ternary_add_arbiter
  import ternary_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 27,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic  [NUM_REQ-1:0]             req_valid,
  output logic  [NUM_REQ-1:0]             req_ready,
  input  trit_t [NUM_REQ-1:0][WIDTH-1:0]  req_a,
  input  trit_t [NUM_REQ-1:0][WIDTH-1:0]  req_b,
  input  logic  [NUM_REQ-1:0]             req_sub,
  input  logic  [NUM_REQ-1:0]             req_first,
  input  logic  [NUM_REQ-1:0]             req_last,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic  [ID_W-1:0]                resp_id,
  output trit_t [WIDTH-1:0]               resp_sum,
  output trit_t                           resp_cout,
  output logic                            resp_err
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  trit_t             carry_q, carry_d;
  logic              resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  trit_t [WIDTH-1:0] resp_sum_q, resp_sum_d;
  trit_t             resp_cout_q, resp_cout_d;

  logic [NUM_REQ-1:0] rr_grant, grant;
  logic               can_accept, accept;
  logic [ID_W-1:0]    g_idx;
  trit_t [WIDTH-1:0]  a_sel, b_sel, b_eff, sum;
  logic               sub_sel, first_sel, last_sel;
  trit_t              cin, cout;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (rr_grant)
  );

  // Grant source (scan when idle, lock owner when locked) and operand mux.
  always_comb begin
    grant = rr_grant;
    if (state_q == ARB_LOCKED) begin
      for (int j = 0; j < NUM_REQ; j++) grant[j] = (lock_id_q == ID_W'(j));
    end
    g_idx     = '0;
    a_sel     = '0;
    b_sel     = '0;
    sub_sel   = 1'b0;
    first_sel = 1'b0;
    last_sel  = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) begin
        g_idx     = ID_W'(j);
        a_sel     = req_a[j];
        b_sel     = req_b[j];
        sub_sel   = req_sub[j];
        first_sel = req_first[j];
        last_sel  = req_last[j];
      end
    end
  end

  // A beat can land whenever the output register is empty or being drained.
  assign can_accept = (!resp_valid_q || resp_ready) && !rst;
  assign req_ready  = grant & {NUM_REQ{can_accept}};
  assign accept     = |(req_valid & req_ready);

  // Trit-wise negation of B for subtraction; no +1 fix-up in balanced ternary.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) b_eff[i] = sub_sel ? trit_neg(b_sel[i]) : b_sel[i];
  end

  assign cin = first_sel ? T_ZERO : carry_q;

  ternary_cla #(.WIDTH(WIDTH)) u_cla (
    .a    (a_sel),
    .b    (b_eff),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  // Arbiter FSM, carry chain and response register next-state.
  always_comb begin
    state_d      = state_q;
    lock_id_d    = lock_id_q;
    rr_ptr_d     = rr_ptr_q;
    carry_d      = carry_q;
    resp_valid_d = resp_valid_q && !resp_ready;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    resp_cout_d  = resp_cout_q;
    if (accept) begin
      carry_d      = cout;
      resp_valid_d = 1'b1;
      resp_id_d    = g_idx;
      resp_sum_d   = sum;
      resp_cout_d  = cout;
      if (last_sel) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = (g_idx == ID_W'(NUM_REQ - 1)) ? '0 : g_idx + ID_W'(1);
      end else begin
        state_d   = ARB_LOCKED;
        lock_id_d = g_idx;
      end
    end
  end

  // State registers; reset drops lock, pending response and carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      lock_id_q    <= '0;
      rr_ptr_q     <= '0;
      carry_q      <= T_ZERO;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      resp_cout_q  <= T_ZERO;
    end else begin
      state_q      <= state_d;
      lock_id_q    <= lock_id_d;
      rr_ptr_q     <= rr_ptr_d;
      carry_q      <= carry_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      resp_cout_q  <= resp_cout_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_cout  = resp_cout_q;

`ifdef TERNARY_ADD_ARB_INVALID_CHK_EN
  logic err_q, err_d, bad;

  // Flag any invalid trit among the accepted operands or the selected carry in.
  always_comb begin
    bad = (cin == T_INVALID);
    for (int i = 0; i < WIDTH; i++) begin
      bad = bad | (a_sel[i] == T_INVALID) | (b_sel[i] == T_INVALID);
    end
    err_d = accept ? bad : err_q;
  end

  // Error flag travels with the response register.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ternary_add_arbiter.sv
// Bench for ternary_add_arbiter: directed scenarios plus random traffic,
// checked against an integer-arithmetic model of arbitration and addition.
module tb_ternary_add_arbiter;
  import ternary_pkg::*;

  localparam int NR = 4;
  localparam int W  = 27;
  localparam longint P3 = 64'd7625597484987;   // 3^27
  localparam longint H  = (P3 - 1) / 2;

  typedef trit_t [W-1:0] word_t;
  typedef struct { int id; longint sum; longint cout; } resp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NR-1:0]             req_valid, req_ready, req_sub, req_first, req_last;
  trit_t [NR-1:0][W-1:0]     req_a, req_b;
  logic                      resp_valid, resp_ready, resp_err;
  logic [1:0]                resp_id;
  trit_t [W-1:0]             resp_sum;
  trit_t                     resp_cout;

  ternary_add_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_first(req_first),
    .req_last(req_last), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  resp_t q[$];
  int gnt_log[$];
  bit m_locked; int m_lock, m_ptr; longint m_carry;

  task automatic chk(string tag, longint act, longint ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, ex);
    end
  endtask

  function automatic longint tv(trit_t t);
    if (t == T_POS_ONE) return 1;
    if (t == T_NEG_ONE) return -1;
    return 0;
  endfunction

  function automatic longint from_trits(word_t v);
    longint r = 0;
    for (int i = W - 1; i >= 0; i--) r = r * 3 + tv(v[i]);
    return r;
  endfunction

  function automatic word_t to_trits(longint v);
    word_t w; longint x = v; longint r;
    for (int i = 0; i < W; i++) begin
      r = x % 3; if (r < 0) r += 3;
      if (r == 0)      begin w[i] = T_ZERO;    x = x / 3;       end
      else if (r == 1) begin w[i] = T_POS_ONE; x = (x - 1) / 3; end
      else             begin w[i] = T_NEG_ONE; x = (x + 1) / 3; end
    end
    return w;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < W; i++) begin
      case ($urandom_range(0, 2))
        0: w[i] = T_ZERO;
        1: w[i] = T_POS_ONE;
        default: w[i] = T_NEG_ONE;
      endcase
    end
    return w;
  endfunction

  task automatic clear();
    req_valid = '0; req_sub = '0; req_first = '0; req_last = '0;
  endtask

  task automatic beat(int r, longint a, longint b, bit sub, bit first, bit last);
    req_valid[r] = 1'b1; req_a[r] = to_trits(a); req_b[r] = to_trits(b);
    req_sub[r] = sub; req_first[r] = first; req_last[r] = last;
  endtask

  // One clock: check response/grant against the model, advance the model.
  task automatic step();
    int eg, gg, nrdy; bit stall; longint va, vb, cin, tot, co; resp_t e;
    #1;
    stall = resp_valid && !resp_ready;
    chk("resp_valid", resp_valid, q.size() != 0);
    if (resp_valid && resp_ready && q.size() != 0) begin
      e = q.pop_front();
      chk("resp_id", resp_id, e.id);
      chk("resp_sum", from_trits(resp_sum), e.sum);
      chk("resp_cout", tv(resp_cout), e.cout);
      chk("resp_err", resp_err, 0);
    end
    eg = -1;
    if (m_locked) begin
      if (req_valid[m_lock]) eg = m_lock;
    end else begin
      for (int k = 0; k < NR; k++) if (eg < 0 && req_valid[(m_ptr + k) % NR]) eg = (m_ptr + k) % NR;
    end
    if (stall || rst) eg = -1;
    gg = -1; nrdy = 0;
    for (int j = 0; j < NR; j++) begin
      if (req_ready[j]) nrdy++;
      if (req_ready[j] && req_valid[j]) gg = j;
    end
    chk("ready_onehot", nrdy <= 1, 1);
    chk("grant", gg, eg);
    if (stall) chk("stall_ready", req_ready, 0);
    if (rst)   chk("rst_ready", req_ready, 0);
    if (gg >= 0) gnt_log.push_back(gg);
    if (eg >= 0) begin
      va = from_trits(req_a[eg]); vb = from_trits(req_b[eg]);
      cin = req_first[eg] ? 0 : m_carry;
      tot = va + (req_sub[eg] ? -vb : vb) + cin;
      co = (tot > H) ? 1 : (tot < -H) ? -1 : 0;
      e.id = eg; e.sum = tot - co * P3; e.cout = co;
      q.push_back(e);
      m_carry = co;
      if (req_last[eg]) begin m_locked = 0; m_ptr = (eg + 1) % NR; end
      else begin m_locked = 1; m_lock = eg; end
    end
    if (rst) begin q.delete(); m_locked = 0; m_ptr = 0; m_carry = 0; end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; clear(); req_valid = '1; resp_ready = 1'b1;
    req_a = '0; req_b = '0;
    m_locked = 0; m_lock = 0; m_ptr = 0; m_carry = 0;
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0; clear();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_sum", resp_sum, 0);
    chk("rst_resp_cout", resp_cout, 0);
    chk("rst_resp_err", resp_err, 0);

    // single add
    beat(0, 13, 1, 0, 1, 1); step(); clear();
    chk("add_sum", from_trits(resp_sum), 14);
    chk("add_cout", tv(resp_cout), 0);
    chk("add_id", resp_id, 0);
    // subtract
    beat(1, 5, 20, 1, 1, 1); step(); clear();
    chk("sub_sum", from_trits(resp_sum), -15);
    chk("sub_cout", tv(resp_cout), 0);
    chk("sub_id", resp_id, 1);
    // overflow
    beat(2, H, 1, 0, 1, 1); step(); clear();
    chk("ovf_sum", from_trits(resp_sum), -H);
    chk("ovf_cout", tv(resp_cout), 1);
    chk("ovf_id", resp_id, 2);
    // two-word chain with competing requesters
    beat(0, 7, 7, 0, 1, 1); beat(1, 2, 2, 0, 1, 1); beat(3, H, 1, 0, 1, 0);
    step();
    chk("chain1_id", resp_id, 3);
    beat(3, 0, 0, 0, 0, 1);
    step();
    chk("chain2_id", resp_id, 3);
    chk("chain2_sum", from_trits(resp_sum), 1);
    req_valid[3] = 1'b0;
    step();
    chk("after_chain_id", resp_id, 0);
    req_valid[0] = 1'b0;
    step(); clear(); step();

    // reset while locked
    beat(1, H, 1, 0, 1, 0); step(); clear();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rstlk_valid", resp_valid, 0);
    beat(2, 1, 1, 0, 0, 1); step(); clear();
    chk("rstlk_id", resp_id, 2);
    chk("rstlk_sum", from_trits(resp_sum), 2);
    step();
    rst = 1'b1; step(); rst = 1'b0;

    // fairness with toggling backpressure
    gnt_log.delete();
    for (int r = 0; r < NR; r++) beat(r, from_trits(rand_word()) / 2, from_trits(rand_word()) / 2, 0, 1, 1);
    for (int c = 0; c < 10; c++) begin resp_ready = (c % 2 == 0); step(); end
    chk("fair_count", gnt_log.size(), 5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) chk("fair_order", gnt_log[i], i % NR);
    clear(); resp_ready = 1'b1; step(); step();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int r = 0; r < NR; r++) begin
        req_valid[r] = ($urandom_range(0, 9) < 7);
        req_a[r] = rand_word(); req_b[r] = rand_word();
        req_sub[r] = $urandom_range(0, 1); req_first[r] = $urandom_range(0, 1);
        req_last[r] = $urandom_range(0, 1);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0; clear(); resp_ready = 1'b1; step(); step();
    chk("drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
